dkong_sound_latch: RTL and testbench
====================================

# dkong_sound_latch

Main-CPU-side command interface to the `dkong_sound` board. It decodes Z80 memory writes to the sound command addresses and holds the latched values on `bg_port`, `sfx_port`, `subsfx_port` and `audio_irq`. It also returns the sound CPU's acknowledge to the main CPU's IN2 port through a synchronizer. It sits between the Z80 bus fabric and `dkong_sound`, clocked by the master clock.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flop count of the `audio_ack` synchronizer (minimum 2).

Ports:
- `masterclk`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `game_type`  in  2  loader configuration; `2'b11` = DJR.
- `cpu_addr`  in  16  Z80 address bus.
- `cpu_dout`  in  8  Z80 write data.
- `cpu_mreq_n`  in  1  Z80 memory request, active low.
- `cpu_wr_n`  in  1  Z80 write strobe, active low.
- `audio_ack`  in  1  acknowledge from `dkong_sound`; asynchronous to `masterclk`.
- `bg_port`  out  5  7C00 background-tune latch.
- `sfx_port`  out  8  7D00–7D07 addressable bit latch.
- `subsfx_port`  out  1  7C81 latch (DJR only).
- `audio_irq`  out  1  sound CPU interrupt, active low (feeds `int_n`).
- `in2_ack`  out  1  synchronized `audio_ack`, for the IN2 read mux.
- `cmd_strobe`  out  1  one-cycle pulse on every committed write to a decoded address.

## Operation
- Bus strobe `wr_act = ~cpu_mreq_n & ~cpu_wr_n`, sampled each `masterclk`.
- Write FSM states:
  - `WAIT_REL`: reset state. Go to `IDLE` when `wr_act`=0.
  - `IDLE`: go to `ARM` when `wr_act`=1; capture `cpu_addr` and `cpu_dout`.
  - `ARM`: if `wr_act`=1, go to `COMMIT`. Otherwise the glitch is rejected and the FSM returns to `IDLE`.
  - `COMMIT`: apply the captured write for one cycle, then go to `WAIT_REL`.
- Each bus write commits exactly once, however long the strobe is held.
- Decode on the captured address, exact match only. Every other address is ignored: no latch change, no `cmd_strobe`.
  - `16'h7C00`: `bg_port` ← `data[4:0]`.
  - `16'h7D00`–`16'h7D07`: `sfx_port[addr[2:0]]` ← `data[0]`. Other bits are held (74LS259 addressable-latch behaviour).
  - `16'h7D80`: `audio_irq` ← `~data[0]`. Writing 1 asserts the interrupt; writing 0 releases it.
  - `16'h7C81`: `subsfx_port` ← `data[0]` only when `game_type == 2'b11`. For any other game type the write is ignored, with no `cmd_strobe`.
- `cmd_strobe` is high during the `COMMIT` cycle of a decoded write.
- `in2_ack` is `audio_ack` passed through a `SYNC_STAGES`-deep flop chain. It has no other logic.
- A change of `game_type` has no effect on already-latched values.

## Timing
- Reset values:
  - `bg_port`=0, `sfx_port`=0, `subsfx_port`=0.
  - `audio_irq`=1 (deasserted).
  - `in2_ack`=0, `cmd_strobe`=0.
  - FSM in `WAIT_REL`.
- Let cycle N be the first sampled `wr_act`=1 (FSM in `IDLE`):
  - Address and data are captured at N.
  - `ARM` holds at N+1.
  - `COMMIT` is at N+2.
  - Latch outputs and `cmd_strobe` are visible after the N+2 edge.
- Minimum strobe width: 2 cycles. A 1-cycle strobe is discarded.
- Minimum write-to-write spacing: strobe low 2 cycles, then high at least 1 cycle.
- `in2_ack` latency is `SYNC_STAGES` edges from a stable `audio_ack`.
- Reset asserted mid-write: all outputs return to reset values immediately (asynchronously). No partial commit occurs.
- Reset released while the strobe is still low: the FSM stays in `WAIT_REL`, and that write is never committed.
- Writes to the same 7D0x bit back-to-back each commit in order. The last one wins.

## Structure
- `dkong_sound_pkg` holds:
  - address constants `ADDR_BG`, `ADDR_SFX_BASE`, `ADDR_IRQ`, `ADDR_SUBSFX`;
  - `GAME_DJR = 2'b11`;
  - the FSM enum `wr_state_t` (`WAIT_REL`, `IDLE`, `ARM`, `COMMIT`).
- Sub-module `dkong_ls259`: 8-bit addressable latch. Ports: clock, reset, enable, 3-bit address, data bit, 8-bit output. It is instantiated once for `sfx_port`.
- The synchronizer is inline; it is not a separate module.

## Test plan
- Reset, then release with bus idle: `bg_port`=0, `sfx_port`=8'h00, `subsfx_port`=0, `audio_irq`=1, `in2_ack`=0.
- Write 8'hFF to 7C00 with a 3-cycle strobe: `bg_port`=5'h1F from the N+2 edge onward; one `cmd_strobe` pulse; `sfx_port` unchanged.
- Write D0=1 to 7D01, then 7D07, then D0=0 to 7D01: `sfx_port` = 8'h02, then 8'h82, then 8'h80; three `cmd_strobe` pulses.
- Write 1 then 0 to 7D80: `audio_irq` goes 1→0→1. Hold the strobe 10 cycles on the first write: exactly one commit.
- Write 1 to 7C81 with `game_type`=2'b00: `subsfx_port` stays 0, no `cmd_strobe`. Repeat with `game_type`=2'b11: `subsfx_port`=1.
- Apply a 1-cycle strobe to 7C00: ignored.
- Assert `rst` during `ARM` of a 7C00 write, then release while the strobe is low: `bg_port` stays 0.
- Toggle `audio_ack`: `in2_ack` follows exactly `SYNC_STAGES` edges later.

Source files
------------

// File: rtl/dkong_sound_pkg.sv
// Shared constants and types for the main-CPU side of the Donkey Kong sound interface.
// The sound command address map, the DJR game code and the write-FSM states.
package dkong_sound_pkg;

  localparam logic [15:0] ADDR_BG       = 16'h7C00;
  localparam logic [15:0] ADDR_SFX_BASE = 16'h7D00;
  localparam logic [15:0] ADDR_IRQ      = 16'h7D80;
  localparam logic [15:0] ADDR_SUBSFX   = 16'h7C81;
  localparam logic [1:0]  GAME_DJR      = 2'b11;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    ARM,
    COMMIT
  } wr_state_t;

  // The 7D00-7D07 window: the low three address bits select the latch bit.
  function automatic logic is_sfx_addr(input logic [15:0] a);
    return (a & 16'hFFF8) == ADDR_SFX_BASE;
  endfunction

endpackage

// File: rtl/dkong_ls259.sv
// 8-bit addressable latch modelled on the 74LS259.
// When enabled, only the addressed bit takes the data bit; all other bits hold.
module dkong_ls259 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] addr,
  input  logic       d,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic [7:0] w_q_next;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign w_q_next[gi] = (en && (addr == 3'(gi))) ? d : r_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 8'h00;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dkong_sound_latch.sv
// Decodes main-CPU writes to the sound command addresses into held latches and
// returns the sound CPU acknowledge through a synchronizer for the IN2 port.
module dkong_sound_latch
  import dkong_sound_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        masterclk,
  input  logic        rst,
  input  logic [1:0]  game_type,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        audio_ack,
  output logic [4:0]  bg_port,
  output logic [7:0]  sfx_port,
  output logic        subsfx_port,
  output logic        audio_irq,
  output logic        in2_ack,
  output logic        cmd_strobe
);

  logic        w_wr_act;
  wr_state_t   r_state;
  wr_state_t   w_state_next;
  logic        w_capture;
  logic [15:0] r_addr;
  logic [4:0]  r_data;

  assign w_wr_act = ~cpu_mreq_n & ~cpu_wr_n;

  // WAIT_REL forces a strobe release between commits, so a held strobe commits once.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      WAIT_REL: if (!w_wr_act) w_state_next = IDLE;
      IDLE: begin
        if (w_wr_act) begin
          w_state_next = ARM;
          w_capture    = 1'b1;
        end
      end
      ARM:      w_state_next = w_wr_act ? COMMIT : IDLE;
      COMMIT:   w_state_next = WAIT_REL;
      default:  w_state_next = WAIT_REL;
    endcase
  end

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_REL;
      r_addr  <= 16'h0000;
      r_data  <= 5'h00;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_addr <= cpu_addr;
        r_data <= cpu_dout[4:0];
      end
    end
  end

  logic w_commit;
  logic w_hit_bg;
  logic w_hit_sfx;
  logic w_hit_irq;
  logic w_hit_sub;
  logic w_hit_any;

  assign w_commit  = (r_state == COMMIT);
  assign w_hit_bg  = w_commit && (r_addr == ADDR_BG);
  assign w_hit_sfx = w_commit && is_sfx_addr(r_addr);
  assign w_hit_irq = w_commit && (r_addr == ADDR_IRQ);
  // The sub-effect latch only exists on the DJR board; elsewhere 7C81 is unmapped.
  assign w_hit_sub = w_commit && (r_addr == ADDR_SUBSFX) && (game_type == GAME_DJR);
  assign w_hit_any = w_hit_bg | w_hit_sfx | w_hit_irq | w_hit_sub;

  logic [4:0] r_bg;
  logic       r_irq;
  logic       r_sub;
  logic       r_cmd_strobe;

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      r_bg         <= 5'h00;
      r_irq        <= 1'b1;
      r_sub        <= 1'b0;
      r_cmd_strobe <= 1'b0;
    end else begin
      r_cmd_strobe <= w_hit_any;
      if (w_hit_bg)  r_bg  <= r_data;
      if (w_hit_irq) r_irq <= ~r_data[0];
      if (w_hit_sub) r_sub <= r_data[0];
    end
  end

  dkong_ls259 u_sfx_latch (
    .clk  (masterclk),
    .rst  (rst),
    .en   (w_hit_sfx),
    .addr (r_addr[2:0]),
    .d    (r_data[0]),
    .q    (sfx_port)
  );

  logic [SYNC_STAGES-1:0] r_ack_sync;

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], audio_ack};
    end
  end

  assign bg_port     = r_bg;
  assign subsfx_port = r_sub;
  assign audio_irq   = r_irq;
  assign in2_ack     = r_ack_sync[SYNC_STAGES-1];
  assign cmd_strobe  = r_cmd_strobe;

endmodule

// File: tb/tb_dkong_sound_latch.sv
// Directed bench for dkong_sound_latch: each scenario task drives bus writes and
// compares the latches, the strobe count and the ack synchronizer against hand values.
module tb_dkong_sound_latch;

  localparam int SYNC_STAGES = 2;

  logic        masterclk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  game_type = 2'b00;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        audio_ack = 1'b0;
  logic [4:0]  bg_port;
  logic [7:0]  sfx_port;
  logic        subsfx_port;
  logic        audio_irq;
  logic        in2_ack;
  logic        cmd_strobe;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;

  dkong_sound_latch #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .masterclk   (masterclk),
    .rst         (rst),
    .game_type   (game_type),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_mreq_n  (cpu_mreq_n),
    .cpu_wr_n    (cpu_wr_n),
    .audio_ack   (audio_ack),
    .bg_port     (bg_port),
    .sfx_port    (sfx_port),
    .subsfx_port (subsfx_port),
    .audio_irq   (audio_irq),
    .in2_ack     (in2_ack),
    .cmd_strobe  (cmd_strobe)
  );

  always #5 masterclk = ~masterclk;

  always @(negedge masterclk) begin
    if (cmd_strobe === 1'b1) strobe_cnt++;
  end

  task automatic step();
    @(posedge masterclk);
    #1;
  endtask

  task automatic bus_on(input logic [15:0] a, input logic [7:0] d);
    cpu_addr   = a;
    cpu_dout   = d;
    cpu_mreq_n = 1'b0;
    cpu_wr_n   = 1'b0;
  endtask

  task automatic bus_off();
    cpu_mreq_n = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  // Strobe high for `width` sampled edges, then idle long enough for commit and re-arm.
  task automatic write_cmd(input logic [15:0] a, input logic [7:0] d, input int width);
    bus_on(a, d);
    repeat (width) step();
    bus_off();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    n_cmp++; if (bg_port !== 5'h00) begin n_bad++; $display("FAIL reset_bg got=%h want=00", bg_port); end
    n_cmp++; if (sfx_port !== 8'h00) begin n_bad++; $display("FAIL reset_sfx got=%h want=00", sfx_port); end
    n_cmp++; if (subsfx_port !== 1'b0) begin n_bad++; $display("FAIL reset_subsfx got=%b want=0", subsfx_port); end
    n_cmp++; if (audio_irq !== 1'b1) begin n_bad++; $display("FAIL reset_irq got=%b want=1", audio_irq); end
    n_cmp++; if (in2_ack !== 1'b0) begin n_bad++; $display("FAIL reset_in2 got=%b want=0", in2_ack); end
    n_cmp++; if (cmd_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%b want=0", cmd_strobe); end
    $display("reset: bg=%h sfx=%h sub=%b irq=%b in2=%b", bg_port, sfx_port, subsfx_port, audio_irq, in2_ack);
  endtask

  task automatic test_bg();
    int s0;
    s0 = strobe_cnt;
    bus_on(16'h7C00, 8'hFF);
    step();  // edge N: capture
    n_cmp++; if (bg_port !== 5'h00) begin n_bad++; $display("FAIL bg_at_N got=%h want=00", bg_port); end
    step();  // edge N+1: ARM -> COMMIT
    n_cmp++; if (bg_port !== 5'h00) begin n_bad++; $display("FAIL bg_at_N1 got=%h want=00", bg_port); end
    n_cmp++; if (cmd_strobe !== 1'b0) begin n_bad++; $display("FAIL strobe_early got=%b want=0", cmd_strobe); end
    step();  // edge N+2: commit
    n_cmp++; if (bg_port !== 5'h1F) begin n_bad++; $display("FAIL bg_at_N2 got=%h want=1f", bg_port); end
    n_cmp++; if (cmd_strobe !== 1'b1) begin n_bad++; $display("FAIL strobe_N2 got=%b want=1", cmd_strobe); end
    bus_off();
    repeat (3) step();
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL bg_strobes got=%0d want=1", strobe_cnt - s0); end
    n_cmp++; if (sfx_port !== 8'h00) begin n_bad++; $display("FAIL bg_sfx_held got=%h want=00", sfx_port); end
    $display("write 7C00=FF: bg=%h strobes=%0d", bg_port, strobe_cnt - s0);
  endtask

  task automatic test_sfx();
    int s0;
    s0 = strobe_cnt;
    write_cmd(16'h7D01, 8'h01, 2);
    n_cmp++; if (sfx_port !== 8'h02) begin n_bad++; $display("FAIL sfx_w1 got=%h want=02", sfx_port); end
    $display("write 7D01=1: sfx=%h", sfx_port);
    write_cmd(16'h7D07, 8'h01, 3);
    n_cmp++; if (sfx_port !== 8'h82) begin n_bad++; $display("FAIL sfx_w2 got=%h want=82", sfx_port); end
    $display("write 7D07=1: sfx=%h", sfx_port);
    write_cmd(16'h7D01, 8'hFE, 2);
    n_cmp++; if (sfx_port !== 8'h80) begin n_bad++; $display("FAIL sfx_w3 got=%h want=80", sfx_port); end
    n_cmp++; if (strobe_cnt - s0 !== 3) begin n_bad++; $display("FAIL sfx_strobes got=%0d want=3", strobe_cnt - s0); end
    n_cmp++; if (bg_port !== 5'h1F) begin n_bad++; $display("FAIL sfx_bg_held got=%h want=1f", bg_port); end
    $display("write 7D01=0: sfx=%h strobes=%0d", sfx_port, strobe_cnt - s0);
  endtask

  task automatic test_irq();
    int s0;
    s0 = strobe_cnt;
    write_cmd(16'h7D80, 8'h01, 10);
    n_cmp++; if (audio_irq !== 1'b0) begin n_bad++; $display("FAIL irq_assert got=%b want=0", audio_irq); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL irq_long_strobes got=%0d want=1", strobe_cnt - s0); end
    $display("write 7D80=1 (10-cycle strobe): irq=%b strobes=%0d", audio_irq, strobe_cnt - s0);
    write_cmd(16'h7D80, 8'h00, 2);
    n_cmp++; if (audio_irq !== 1'b1) begin n_bad++; $display("FAIL irq_release got=%b want=1", audio_irq); end
    $display("write 7D80=0: irq=%b", audio_irq);
  endtask

  task automatic test_subsfx();
    int s0;
    game_type = 2'b00;
    s0 = strobe_cnt;
    write_cmd(16'h7C81, 8'h01, 2);
    n_cmp++; if (subsfx_port !== 1'b0) begin n_bad++; $display("FAIL sub_nondjr got=%b want=0", subsfx_port); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL sub_nondjr_strobes got=%0d want=0", strobe_cnt - s0); end
    $display("write 7C81=1 game=00: sub=%b strobes=%0d", subsfx_port, strobe_cnt - s0);
    game_type = 2'b11;
    s0 = strobe_cnt;
    write_cmd(16'h7C81, 8'h01, 2);
    n_cmp++; if (subsfx_port !== 1'b1) begin n_bad++; $display("FAIL sub_djr got=%b want=1", subsfx_port); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL sub_djr_strobes got=%0d want=1", strobe_cnt - s0); end
    $display("write 7C81=1 game=11: sub=%b strobes=%0d", subsfx_port, strobe_cnt - s0);
    game_type = 2'b00;
    repeat (2) step();
    n_cmp++; if (subsfx_port !== 1'b1) begin n_bad++; $display("FAIL sub_gt_change got=%b want=1", subsfx_port); end
    $display("game_type -> 00: sub=%b", subsfx_port);
  endtask

  task automatic test_glitch_and_unmapped();
    int s0;
    s0 = strobe_cnt;
    write_cmd(16'h7C00, 8'h0A, 1);
    n_cmp++; if (bg_port !== 5'h1F) begin n_bad++; $display("FAIL glitch_bg got=%h want=1f", bg_port); end
    write_cmd(16'h7C01, 8'h0A, 2);
    write_cmd(16'h7D08, 8'h01, 2);
    n_cmp++; if (bg_port !== 5'h1F) begin n_bad++; $display("FAIL unmapped_bg got=%h want=1f", bg_port); end
    n_cmp++; if (sfx_port !== 8'h80) begin n_bad++; $display("FAIL unmapped_sfx got=%h want=80", sfx_port); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL ignored_strobes got=%0d want=0", strobe_cnt - s0); end
    $display("glitch/unmapped writes: bg=%h sfx=%h strobes=%0d", bg_port, sfx_port, strobe_cnt - s0);
  endtask

  task automatic test_back_to_back();
    bus_on(16'h7D03, 8'h01);
    repeat (2) step();
    bus_off();
    step();  // commit edge of first write
    n_cmp++; if (sfx_port !== 8'h88) begin n_bad++; $display("FAIL b2b_first got=%h want=88", sfx_port); end
    step();
    bus_on(16'h7D03, 8'h00);
    repeat (2) step();
    bus_off();
    repeat (3) step();
    n_cmp++; if (sfx_port !== 8'h80) begin n_bad++; $display("FAIL b2b_last got=%h want=80", sfx_port); end
    $display("back-to-back 7D03=1,0: sfx=%h", sfx_port);
  endtask

  task automatic test_reset_mid_write();
    int s0;
    bus_on(16'h7C00, 8'h15);
    step();  // capture; FSM in ARM
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bg_port !== 5'h00) begin n_bad++; $display("FAIL rst_async_bg got=%h want=00", bg_port); end
    n_cmp++; if (sfx_port !== 8'h00) begin n_bad++; $display("FAIL rst_async_sfx got=%h want=00", sfx_port); end
    n_cmp++; if (audio_irq !== 1'b1) begin n_bad++; $display("FAIL rst_async_irq got=%b want=1", audio_irq); end
    repeat (2) step();
    bus_off();
    step();
    s0 = strobe_cnt;
    rst = 1'b0;
    repeat (4) step();
    n_cmp++; if (bg_port !== 5'h00) begin n_bad++; $display("FAIL rst_no_commit_bg got=%h want=00", bg_port); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL rst_no_commit_strobes got=%0d want=0", strobe_cnt - s0); end
    $display("reset mid-write 7C00=15: bg=%h strobes=%0d", bg_port, strobe_cnt - s0);
    write_cmd(16'h7C00, 8'h15, 2);
    n_cmp++; if (bg_port !== 5'h15) begin n_bad++; $display("FAIL post_rst_write got=%h want=15", bg_port); end
    $display("write 7C00=15 after reset: bg=%h", bg_port);
  endtask

  task automatic test_ack();
    audio_ack = 1'b1;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      step();
      n_cmp++;
      if (in2_ack !== (k == SYNC_STAGES)) begin
        n_bad++; $display("FAIL ack_rise_edge%0d got=%b want=%b", k, in2_ack, (k == SYNC_STAGES));
      end
    end
    $display("audio_ack 0->1: in2=%b after %0d edges", in2_ack, SYNC_STAGES);
    audio_ack = 1'b0;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      step();
      n_cmp++;
      if (in2_ack !== (k != SYNC_STAGES)) begin
        n_bad++; $display("FAIL ack_fall_edge%0d got=%b want=%b", k, in2_ack, (k != SYNC_STAGES));
      end
    end
    $display("audio_ack 1->0: in2=%b after %0d edges", in2_ack, SYNC_STAGES);
  endtask

  initial begin
    test_reset();
    test_bg();
    test_sfx();
    test_irq();
    test_subsfx();
    test_glitch_and_unmapped();
    test_back_to_back();
    test_reset_mid_write();
    test_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
